// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the MIPS E stage: runs mult/multu/div/divu over a fixed
// number of busy cycles, owns HI/LO, and raises md_stall to hold MDU instructions in D.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        MD_write_enable,
  input  logic        MDaddress,
  input  logic        md_use_D,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_rdata,
  output logic        busy,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MULT  = 3'd2,
    OP_DIVU  = 3'd3,
    OP_DIV   = 3'd4
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      hi_n, lo_n, hi_n_d, lo_n_d, hi_d, lo_d;
  logic             busy_d;

  // Operand datapath; signed divide is done on magnitudes so 0x80000000 / -1 needs no special case.
  logic [63:0] prod_u, prod_s;
  logic        signed_div, dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag, quo_mag, rem_mag, quo, rem;

  assign prod_u     = {32'b0, rs_val} * {32'b0, rt_val};
  assign prod_s     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign signed_div = (start == OP_DIV);
  assign dvd_neg    = signed_div & rs_val[31];
  assign dvs_neg    = signed_div & rt_val[31];
  assign dvd_mag    = dvd_neg ? -rs_val : rs_val;
  assign dvs_mag    = dvs_neg ? -rt_val : rt_val;
  assign quo_mag    = dvd_mag / dvs_mag;
  assign rem_mag    = dvd_mag % dvs_mag;
  assign quo        = (dvd_neg ^ dvs_neg) ? -quo_mag : quo_mag;
  assign rem        = dvd_neg ? -rem_mag : rem_mag;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state;
    cnt_d   = cnt;
    hi_n_d  = hi_n;
    lo_n_d  = lo_n;
    hi_d    = HI;
    lo_d    = LO;
    busy_d  = busy;
    case (state)
      IDLE: begin
        case (start)
          OP_MULTU: begin
            hi_n_d = prod_u[63:32];
            lo_n_d = prod_u[31:0];
            cnt_d  = MULT_LOAD;
          end
          OP_MULT: begin
            hi_n_d = prod_s[63:32];
            lo_n_d = prod_s[31:0];
            cnt_d  = MULT_LOAD;
          end
          OP_DIVU, OP_DIV: begin
            // A zero divisor parks the current HI/LO as the pending result, so commit is a no-op.
            hi_n_d = (rt_val == 32'd0) ? HI : rem;
            lo_n_d = (rt_val == 32'd0) ? LO : quo;
            cnt_d  = DIV_LOAD;
          end
          default: begin
            if (MD_write_enable) begin
              if (MDaddress) hi_d = rs_val;
              else           lo_d = rs_val;
            end
          end
        endcase
        if (start inside {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV}) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          hi_d    = hi_n;
          lo_d    = lo_n;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pending result registers are reset too, so an aborted operation leaves nothing behind.
      state <= IDLE;
      cnt   <= '0;
      hi_n  <= '0;
      lo_n  <= '0;
      HI    <= '0;
      LO    <= '0;
      busy  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state <= state_d;
      cnt   <= cnt_d;
      hi_n  <= hi_n_d;
      lo_n  <= lo_n_d;
      HI    <= hi_d;
      LO    <= lo_d;
      busy  <= busy_d;
    end
  end

  assign md_rdata = MDaddress ? HI : LO;
  assign md_stall = md_use_D && (busy || (start != OP_NONE));

endmodule
